// File: rtl/dmem_responder_if.sv
// Data-memory request/response channel between the MEM stage (master) and the responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable wait states, byte/half/word lanes and load extension.
// Optional MEM_MISALIGN_TRAP_EN: misaligned half/word accesses return err instead of aligning down.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LATENCY     = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus,
    output logic             busy
);
    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned ADDR_W = IDX_W + 2;
    localparam int unsigned CNT_W  = 4;
    localparam bit          DIRECT = (LATENCY == 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;

    logic               lat_we;
    logic [ADDR_W-1:0]  lat_addr;
    logic [2:0]         lat_funct3;
    logic [31:0]        lat_wdata;

    logic [31:0]        mem [DEPTH_WORDS];
    logic [31:0]        rdata_q;
    logic               err_q;

    logic               ready_c;
    logic               accept_c;
    logic               exec_c;
    logic               a_we;
    logic [ADDR_W-1:0]  a_addr;
    logic [2:0]         a_funct3;
    logic [31:0]        a_wdata;
    logic [IDX_W-1:0]   idx_c;
    logic [31:0]        word_c;
    logic [7:0]         byte_c;
    logic [15:0]        half_c;
    logic [31:0]        load_c;
    logic               illegal_c;
    logic               misalign_c;
    logic               err_c;
    logic [3:0]         be_c;
    logic [31:0]        wmask_c;
    logic [31:0]        wdata_c;
    logic               unused_c;

    assign ready_c  = (state == IDLE) && !rst;
    assign accept_c = bus.req_valid && ready_c;
    assign unused_c = ^bus.req_addr[31:ADDR_W];

    // Single-cycle latency executes straight off the bus; otherwise off the latched request.
    always_comb begin
        a_we     = lat_we;
        a_addr   = lat_addr;
        a_funct3 = lat_funct3;
        a_wdata  = lat_wdata;
        exec_c   = (state == WAIT) && (cnt == CNT_W'(1)) && !rst;
        if (DIRECT) begin
            a_we     = bus.req_we;
            a_addr   = bus.req_addr[ADDR_W-1:0];
            a_funct3 = bus.req_funct3;
            a_wdata  = bus.req_wdata;
            exec_c   = accept_c;
        end
    end

    // Lane selection, extension and error decode for the access being executed.
    always_comb begin
        idx_c  = a_addr[ADDR_W-1:2];
        word_c = mem[idx_c];
        half_c = a_addr[1] ? word_c[31:16] : word_c[15:0];
        case (a_addr[1:0])
            2'd0:    byte_c = word_c[7:0];
            2'd1:    byte_c = word_c[15:8];
            2'd2:    byte_c = word_c[23:16];
            default: byte_c = word_c[31:24];
        endcase

        load_c    = '0;
        illegal_c = 1'b0;
        case (a_funct3)
            3'b000:  load_c = {{24{byte_c[7]}}, byte_c};
            3'b001:  load_c = {{16{half_c[15]}}, half_c};
            3'b010:  load_c = word_c;
            3'b100:  load_c = {24'd0, byte_c};
            3'b101:  load_c = {16'd0, half_c};
            default: illegal_c = 1'b1;
        endcase
        if (a_we) illegal_c = (a_funct3 > 3'd2);

`ifdef MEM_MISALIGN_TRAP_EN
        misalign_c = ((a_funct3[1:0] == 2'b01) && a_addr[0]) ||
                     ((a_funct3[1:0] == 2'b10) && (a_addr[1:0] != 2'b00));
`else
        misalign_c = 1'b0;
`endif
        err_c = illegal_c || misalign_c;

        case (a_funct3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << a_addr[1:0];
                wdata_c = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                be_c    = a_addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{a_wdata[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = a_wdata;
            end
        endcase
        wmask_c = {{8{be_c[3]}}, {8{be_c[2]}}, {8{be_c[1]}}, {8{be_c[0]}}};
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept_c) state_nxt = DIRECT ? RESP : WAIT;
            WAIT:    if (cnt == CNT_W'(1)) state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept_c)
                cnt <= CNT_W'(LATENCY - 1);
            else if (state == WAIT)
                cnt <= cnt - CNT_W'(1);
            if (exec_c) begin
                rdata_q <= (a_we || err_c) ? 32'd0 : load_c;
                err_q   <= err_c;
            end
        end
    end

    // Request capture and storage array are never reset.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            lat_we     <= bus.req_we;
            lat_addr   <= bus.req_addr[ADDR_W-1:0];
            lat_funct3 <= bus.req_funct3;
            lat_wdata  <= bus.req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (exec_c && a_we && !err_c)
            mem[idx_c] <= (word_c & ~wmask_c) | (wdata_c & wmask_c);
    end

    assign bus.req_ready = ready_c;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 and a LATENCY=4 instance share one stimulus driver.
module tb_dmem_responder;
    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_ready;
    logic        busy2;
    logic        busy4;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    dmem_responder_if bus2();
    dmem_responder_if bus4();

    assign bus2.req_valid  = req_valid & ~sel;
    assign bus2.req_we     = req_we;
    assign bus2.req_addr   = req_addr;
    assign bus2.req_funct3 = req_funct3;
    assign bus2.req_wdata  = req_wdata;
    assign bus2.rsp_ready  = rsp_ready;
    assign bus4.req_valid  = req_valid & sel;
    assign bus4.req_we     = req_we;
    assign bus4.req_addr   = req_addr;
    assign bus4.req_funct3 = req_funct3;
    assign bus4.req_wdata  = req_wdata;
    assign bus4.rsp_ready  = rsp_ready;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2.slave), .busy(busy2));
    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) u_dut4 (
        .clk(clk), .rst(rst), .bus(bus4.slave), .busy(busy4));

    logic        m_ready;
    logic        m_valid;
    logic        m_err;
    logic        m_busy;
    logic [31:0] m_rdata;
    assign m_ready = sel ? bus4.req_ready : bus2.req_ready;
    assign m_valid = sel ? bus4.rsp_valid : bus2.rsp_valid;
    assign m_err   = sel ? bus4.rsp_err   : bus2.rsp_err;
    assign m_rdata = sel ? bus4.rsp_rdata : bus2.rsp_rdata;
    assign m_busy  = sel ? busy4          : busy2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request and return just after the accepting edge with the bus scrambled.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wd);
        int n;
        n          = 0;
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_funct3 = f3;
        req_wdata  = wd;
        @(negedge clk);
        while (!m_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = ~we;
        req_addr   = 32'hFFFF_FFFF;
        req_funct3 = 3'b111;
        req_wdata  = 32'hA5A5_A5A5;
    endtask

    // Count negedges from the accepting edge until rsp_valid is seen.
    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!m_valid && lat < 40);
        if (!m_valid) chk("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [2:0] f3, input logic [31:0] wd,
                        input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        issue(we, addr, f3, wd);
        wait_rsp(lat);
        chk({tag, ".lat"},   32'(lat), sel ? 32'd4 : 32'd2);
        chk({tag, ".rdata"}, m_rdata, exp_rdata);
        chk({tag, ".err"},   32'(m_err), 32'(exp_err));
        step();
    endtask

    // Reset while the store is still counting down; no response may ever appear.
    task automatic abort_store(input string tag, input logic [31:0] addr, input logic [31:0] wd);
        logic seen;
        seen = 1'b0;
        issue(1'b1, addr, 3'b010, wd);
        @(negedge clk);
        if (m_valid) seen = 1'b1;
        step();
        rst = 1'b1;
        @(negedge clk);
        if (m_valid) seen = 1'b1;
        step();
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (m_valid) seen = 1'b1;
        end
        chk({tag, ".no_rsp"}, 32'(seen), 32'd0);
        chk({tag, ".busy"},   32'(m_busy), 32'd0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        sel = 1'b0; rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_funct3 = '0; req_wdata = '0; rsp_ready = 1'b1;

        // Reset values on both instances
        repeat (2) begin
            @(negedge clk);
            chk("rst.ready2", 32'(bus2.req_ready), 32'd0);
            chk("rst.ready4", 32'(bus4.req_ready), 32'd0);
        end
        chk("rst.valid2", 32'(bus2.rsp_valid), 32'd0);
        chk("rst.rdata2", bus2.rsp_rdata, 32'd0);
        chk("rst.err2",   32'(bus2.rsp_err), 32'd0);
        chk("rst.busy2",  32'(busy2), 32'd0);
        chk("rst.busy4",  32'(busy4), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst.ready_after", 32'(m_ready), 32'd1);
        step();

        xact("sw10", 1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF, 32'd0, 1'b0);

        xact("lb13",  1'b0, 32'h13, 3'b000, 32'd0, 32'hFFFF_FFDE, 1'b0);
        xact("lbu13", 1'b0, 32'h13, 3'b100, 32'd0, 32'h0000_00DE, 1'b0);
        xact("lh12",  1'b0, 32'h12, 3'b001, 32'd0, 32'hFFFF_DEAD, 1'b0);
        xact("lw10",  1'b0, 32'h10, 3'b010, 32'd0, 32'hDEAD_BEEF, 1'b0);
        xact("lhu10", 1'b0, 32'h10, 3'b101, 32'd0, 32'h0000_BEEF, 1'b0);
        xact("lb11",  1'b0, 32'h11, 3'b000, 32'd0, 32'hFFFF_FFBE, 1'b0);

        xact("sb11",  1'b1, 32'h11, 3'b000, 32'hABCD_EF55, 32'd0, 1'b0);
        xact("lw_sb", 1'b0, 32'h10, 3'b010, 32'd0, 32'hDEAD_55EF, 1'b0);
        xact("sh12",  1'b1, 32'h12, 3'b001, 32'h9999_1234, 32'd0, 1'b0);
        xact("lw_sh", 1'b0, 32'h10, 3'b010, 32'd0, 32'h1234_55EF, 1'b0);

        // Backpressure: response must hold while rsp_ready is low
        rsp_ready = 1'b0;
        issue(1'b0, 32'h10, 3'b010, 32'd0);
        wait_rsp(lat);
        chk("bp.lat", 32'(lat), 32'd2);
        repeat (5) begin
            @(negedge clk);
            chk("bp.valid", 32'(m_valid), 32'd1);
            chk("bp.rdata", m_rdata, 32'h1234_55EF);
            chk("bp.ready", 32'(m_ready), 32'd0);
        end
        step();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp.valid_last", 32'(m_valid), 32'd1);
        @(negedge clk);
        chk("bp.idle_busy",  32'(m_busy), 32'd0);
        chk("bp.idle_ready", 32'(m_ready), 32'd1);
        step();

        xact("st_f3_011", 1'b1, 32'h10, 3'b011, 32'h0, 32'd0, 1'b1);
        xact("lw_keep1",  1'b0, 32'h10, 3'b010, 32'd0, 32'h1234_55EF, 1'b0);
        xact("st_f3_100", 1'b1, 32'h10, 3'b100, 32'hFFFF_FFFF, 32'd0, 1'b1);
        xact("lw_keep2",  1'b0, 32'h10, 3'b010, 32'd0, 32'h1234_55EF, 1'b0);
        xact("ld_f3_011", 1'b0, 32'h10, 3'b011, 32'd0, 32'd0, 1'b1);
        xact("ld_f3_110", 1'b0, 32'h10, 3'b110, 32'd0, 32'd0, 1'b1);
`ifdef MEM_MISALIGN_TRAP_EN
        xact("lw_mis",   1'b0, 32'h12, 3'b010, 32'd0, 32'd0, 1'b1);
        xact("lh_mis",   1'b0, 32'h11, 3'b001, 32'd0, 32'd0, 1'b1);
        xact("sh_mis",   1'b1, 32'h13, 3'b001, 32'h0000_ABCD, 32'd0, 1'b1);
        xact("lw_aftsh", 1'b0, 32'h10, 3'b010, 32'd0, 32'h1234_55EF, 1'b0);
`else
        xact("lw_mis",   1'b0, 32'h12, 3'b010, 32'd0, 32'h1234_55EF, 1'b0);
        xact("lh_mis",   1'b0, 32'h11, 3'b001, 32'd0, 32'h0000_55EF, 1'b0);
        xact("sh_mis",   1'b1, 32'h13, 3'b001, 32'h0000_ABCD, 32'd0, 1'b0);
        xact("lw_aftsh", 1'b0, 32'h10, 3'b010, 32'd0, 32'hABCD_55EF, 1'b0);
`endif

        // LATENCY=4 instance: aborted stores, address wrap, committed store survives reset
        sel = 1'b1;
        xact("l4.sw20",   1'b1, 32'h20, 3'b010, 32'hCAFE_F00D, 32'd0, 1'b0);
        abort_store("l4.abort20", 32'h20, 32'h1);
        xact("l4.lw20a",  1'b0, 32'h20, 3'b010, 32'd0, 32'hCAFE_F00D, 1'b0);
        abort_store("l4.abortwrap", 32'h20 + 4 * DEPTH, 32'h2);
        xact("l4.lw20b",  1'b0, 32'h20, 3'b010, 32'd0, 32'hCAFE_F00D, 1'b0);
        xact("l4.swwrap", 1'b1, 32'h20 + 4 * DEPTH, 3'b010, 32'h77, 32'd0, 1'b0);
        xact("l4.lw20c",  1'b0, 32'h20, 3'b010, 32'd0, 32'h0000_0077, 1'b0);

        rsp_ready = 1'b0;
        issue(1'b1, 32'h24, 3'b010, 32'h99);
        wait_rsp(lat);
        chk("l4.commit.lat", 32'(lat), 32'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("l4.commit.valid", 32'(m_valid), 32'd0);
        chk("l4.commit.ready", 32'(m_ready), 32'd1);
        step();
        xact("l4.lw24",   1'b0, 32'h24, 3'b010, 32'd0, 32'h0000_0099, 1'b0);
        xact("l4.lw24w",  1'b0, 32'h24 + 4 * DEPTH, 3'b010, 32'd0, 32'h0000_0099, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
